cache_refill_ctrl: RTL and testbench

Miss-handling controller on the memory side of the direct-mapped instruction/data cache (1024 lines × 128 bits, 3-bit tag, 15-bit word address). On a cache miss it stalls the CPU, fetches the four 32-bit words of the missing line from main memory over a req/ack handshake, and assembles them into a 128-bit line. It then pulses the cache's write strobe and releases the stall once the cache reports a hit.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/refill_line_buf.sv | 37 +++
 rtl/cache_refill_ctrl.sv | 147 ++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry for the cache miss-refill path.
// Line = 4 words; address = tag(3) | index(10) | offset(2).
package cache_pkg;

   localparam int LINE_WORDS = 4;
   localparam int OFFSET_W   = 2;
   localparam int TAG_W      = 3;
   localparam int INDEX_W    = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      FILL   = 2'd2,
      RESUME = 2'd3
   } refill_state_t;

   // Least significant bit of a word slot inside a line; slot 0 occupies the top word.
   function automatic int slot_lsb(input int word_w, input int slot);
      return (LINE_WORDS - 1 - slot) * word_w;
   endfunction

endpackage

// File: rtl/refill_line_buf.sv
// Four-slot word register that assembles a cache line during a refill.
// Slot k is written on a select match; clr empties the whole line at refill start.
module refill_line_buf
   import cache_pkg::*;
#(
   parameter int WORD_W = 32
)
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         wr_en,
   input  logic [OFFSET_W-1:0]          wr_sel,
   input  logic [WORD_W-1:0]            wr_data,
   output logic [LINE_WORDS*WORD_W-1:0] line
);

   genvar gi;
   generate
      for (gi = 0; gi < LINE_WORDS; gi++) begin : g_slot
         logic [WORD_W-1:0] slot_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               slot_reg <= '0;
            end else if (clr) begin
               slot_reg <= '0;
            end else if (wr_en && (wr_sel == OFFSET_W'(gi))) begin
               slot_reg <= wr_data;
            end
         end

         assign line[slot_lsb(WORD_W, gi) +: WORD_W] = slot_reg;
      end
   endgenerate

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss-refill controller: stalls the CPU, fetches a 4-word line, writes it to the cache.
// Optional refill counter port miss_count is present when CACHE_REFILL_STATS_EN is defined.
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W = 15,
   parameter int WORD_W = 32
)
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_W-1:0]            cpu_addr,
   input  logic                         cpu_rd,
   input  logic                         miss,
   output logic                         stall,
   output logic                         mem_req,
   output logic [ADDR_W-1:0]            mem_addr,
   input  logic                         mem_ack,
   input  logic [WORD_W-1:0]            mem_rdata,
   output logic                         cache_write,
   output logic [LINE_WORDS*WORD_W-1:0] cache_wdata
`ifdef CACHE_REFILL_STATS_EN
   ,
   output logic [31:0]                  miss_count
`endif
);

   localparam int BASE_W = ADDR_W - OFFSET_W;
   localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(LINE_WORDS - 1);

   refill_state_t         state_reg, state_next;
   logic [BASE_W-1:0]     base_reg, base_next;
   logic [OFFSET_W-1:0]   k_reg, k_next;
   logic                  mem_req_reg, mem_req_next;
   logic [ADDR_W-1:0]     mem_addr_reg, mem_addr_next;
   logic                  cache_write_reg, cache_write_next;
   logic                  start_refill;
   logic                  word_accept;
   logic                  unused_offset_bits;

   // The word offset of the missing access is irrelevant: the whole line is fetched from word 0.
   assign unused_offset_bits = ^cpu_addr[OFFSET_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         base_reg        <= '0;
         k_reg           <= '0;
         mem_req_reg     <= 1'b0;
         mem_addr_reg    <= '0;
         cache_write_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         base_reg        <= base_next;
         k_reg           <= k_next;
         mem_req_reg     <= mem_req_next;
         mem_addr_reg    <= mem_addr_next;
         cache_write_reg <= cache_write_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      base_next        = base_reg;
      k_next           = k_reg;
      mem_req_next     = mem_req_reg;
      mem_addr_next    = mem_addr_reg;
      cache_write_next = 1'b0;
      start_refill     = 1'b0;
      word_accept      = 1'b0;

      unique case (state_reg)
         IDLE: begin
            mem_req_next = 1'b0;
            if (cpu_rd && miss) begin
               start_refill  = 1'b1;
               base_next     = cpu_addr[ADDR_W-1:OFFSET_W];
               k_next        = '0;
               mem_req_next  = 1'b1;
               mem_addr_next = {cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
               state_next    = FETCH;
            end
         end

         FETCH: begin
            // Address is rebuilt from the latched base, so later cpu_addr changes cannot leak in
            // and the offset counter wraps inside the line without touching index/tag bits.
            if (mem_ack) begin
               word_accept = 1'b1;
               if (k_reg == LAST_WORD) begin
                  mem_req_next     = 1'b0;
                  cache_write_next = 1'b1;
                  state_next       = FILL;
               end else begin
                  k_next        = k_reg + OFFSET_W'(1);
                  mem_addr_next = {base_reg, k_reg + OFFSET_W'(1)};
               end
            end
         end

         FILL: begin
            state_next = RESUME;
         end

         RESUME: begin
            state_next = IDLE;
         end

         default: begin
            state_next   = IDLE;
            mem_req_next = 1'b0;
         end
      endcase
   end

   refill_line_buf #(
      .WORD_W (WORD_W)
   ) u_line_buf (
      .clk     (clk),
      .rst     (rst),
      .clr     (start_refill),
      .wr_en   (word_accept),
      .wr_sel  (k_reg),
      .wr_data (mem_rdata),
      .line    (cache_wdata)
   );

`ifdef CACHE_REFILL_STATS_EN
   logic [31:0] miss_count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miss_count_reg <= '0;
      end else if (start_refill) begin
         miss_count_reg <= miss_count_reg + 32'd1;
      end
   end

   assign miss_count = miss_count_reg;
`endif

   assign stall       = ~rst & (((state_reg == IDLE) & cpu_rd & miss) | (state_reg != IDLE));
   assign mem_req     = mem_req_reg;
   assign mem_addr    = mem_addr_reg;
   assign cache_write = cache_write_reg;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: stimulus queues expected words/lines/stall lengths,
// a negedge monitor pops and compares. Checks miss_count when CACHE_REFILL_STATS_EN is defined.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

   localparam int ADDR_W = 15;
   localparam int WORD_W = 32;
   localparam int LINE_W = 4 * WORD_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic              cpu_rd = 1'b1;
   logic              miss;
   logic              stall;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack = 1'b0;
   logic [WORD_W-1:0] mem_rdata = '0;
   logic              cache_write;
   logic [LINE_W-1:0] cache_wdata;
`ifdef CACHE_REFILL_STATS_EN
   logic [31:0]       miss_count;
`endif

   int errors = 0;
   int checks = 0;

   logic [ADDR_W-1:0] addr_q[$];
   logic [LINE_W-1:0] line_q[$];
   int                stall_q[$];

   // Memory responder controls
   logic [WORD_W-1:0] data_tag = '0;
   int                wait_cycles = 0;
   logic              ack_force = 1'b0;
   int                wcnt = 0;

   // One-entry cache model: holds the line address last written by the DUT
   logic              cv = 1'b1;
   logic [ADDR_W-3:0] cline = '0;
   logic [ADDR_W-3:0] fill_line = '0;

   assign miss = cpu_rd && !(cv && (cline == cpu_addr[ADDR_W-1:2]));

   cache_refill_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_addr    (cpu_addr),
      .cpu_rd      (cpu_rd),
      .miss        (miss),
      .stall       (stall),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .cache_write (cache_write),
      .cache_wdata (cache_wdata)
`ifdef CACHE_REFILL_STATS_EN
      ,
      .miss_count  (miss_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Memory: acks after wait_cycles idle cycles per word; data = data_tag + word offset
   always begin
      @(posedge clk);
      #1;
      if (rst) begin
         mem_ack = 1'b0;
         wcnt    = 0;
      end else if (ack_force) begin
         mem_ack = 1'b1;
      end else if (mem_req) begin
         if (wcnt == wait_cycles) begin
            mem_ack   = 1'b1;
            mem_rdata = data_tag + 32'(mem_addr[1:0]);
            wcnt      = 0;
         end else begin
            mem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         mem_ack = 1'b0;
         wcnt    = 0;
      end
   end

   always @(posedge clk) begin
      if (!rst && mem_req && mem_ack) fill_line <= mem_addr[ADDR_W-1:2];
      if (!rst && cache_write) begin
         cv    <= 1'b1;
         cline <= fill_line;
      end
   end

   // Monitor
   int                run_len = 0;
   logic              prev_req = 1'b0;
   logic              prev_ack = 1'b0;
   logic              prev_cw = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;

   always @(negedge clk) begin
      if (rst) begin
         run_len  = 0;
         prev_req = 1'b0;
         prev_ack = 1'b0;
         prev_cw  = 1'b0;
      end else begin
         if (prev_req && !prev_ack && mem_req) check("mem_addr_hold", mem_addr, prev_addr);
         if (mem_req && mem_ack) begin
            if (addr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_word: got addr %0h expected none", mem_addr);
            end else begin
               check("mem_addr", mem_addr, addr_q.pop_front());
            end
         end
         if (cache_write) begin
            check("cache_write_1cycle", prev_cw, 1'b0);
            if (line_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_cache_write: got line %0h expected none", cache_wdata);
            end else begin
               check("cache_wdata", cache_wdata, line_q.pop_front());
            end
         end
         if (stall) begin
            run_len++;
         end else if (run_len > 0) begin
            if (stall_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_stall: got %0d cycles expected none", run_len);
            end else begin
               check("stall_cycles", run_len, stall_q.pop_front());
            end
            run_len = 0;
         end
         prev_req  = mem_req;
         prev_ack  = mem_ack;
         prev_cw   = cache_write;
         prev_addr = mem_addr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_words(input int n, input int budget);
      int seen = 0;
      for (int c = 0; c < budget && seen < n; c++) begin
         @(negedge clk);
         if (mem_req && mem_ack) seen++;
      end
      checks++;
      if (seen < n) begin
         errors++;
         $display("FAIL wait_words: got %0d words expected %0d", seen, n);
      end
   endtask

   task automatic wait_fills(input int n, input int budget);
      int seen = 0;
      for (int c = 0; c < budget && seen < n; c++) begin
         @(negedge clk);
         if (cache_write) seen++;
      end
      checks++;
      if (seen < n) begin
         errors++;
         $display("FAIL wait_fills: got %0d writes expected %0d", seen, n);
      end
   endtask

   task automatic refill(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] base,
                         input logic [WORD_W-1:0] tag, input logic [LINE_W-1:0] line,
                         input int waits, input int stall_exp);
      tick();
      data_tag    = tag;
      wait_cycles = waits;
      for (int i = 0; i < 4; i++) addr_q.push_back(base + 15'(i));
      line_q.push_back(line);
      stall_q.push_back(stall_exp);
      cpu_addr = addr;
      cpu_rd   = 1'b1;
      wait_fills(1, 100);
      tick();
      tick();
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_stall", stall, 1'b0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_addr", mem_addr, 15'h0);
      check("rst_cache_write", cache_write, 1'b0);
      check("rst_cache_wdata", cache_wdata, '0);
      cpu_addr = 15'h1235;
      #1;
      check("rst_stall_on_miss", stall, 1'b0);
      cpu_addr = 15'h0000;
      @(negedge clk);
      rst = 1'b0;

      // Hit traffic only
      repeat (3) begin
         @(negedge clk);
         check("hit_stall", stall, 1'b0);
         check("hit_mem_req", mem_req, 1'b0);
      end

      // Zero-wait refill
      refill(15'h1235, 15'h1234, 32'h000000A0,
             128'h000000A0_000000A1_000000A2_000000A3, 0, 7);

      // Two wait cycles per word
      refill(15'h0A11, 15'h0A10, 32'h11110000,
             128'h11110000_11110001_11110002_11110003, 2, 15);

      // Reset after the second word
      tick();
      data_tag    = 32'hBEEF0000;
      wait_cycles = 0;
      addr_q.push_back(15'h2000);
      addr_q.push_back(15'h2001);
      cpu_addr = 15'h2000;
      wait_words(2, 20);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_mem_req", mem_req, 1'b0);
      check("midrst_stall", stall, 1'b0);
      cpu_rd = 1'b0;
      tick();
      check("midrst_mem_req_edge", mem_req, 1'b0);
      check("midrst_cache_write", cache_write, 1'b0);
      @(negedge clk);
      rst       = 1'b0;
      ack_force = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("late_ack_mem_req", mem_req, 1'b0);
         check("late_ack_stall", stall, 1'b0);
      end
      ack_force = 1'b0;
      refill(15'h2002, 15'h2000, 32'hCAFE0000,
             128'hCAFE0000_CAFE0001_CAFE0002_CAFE0003, 0, 7);

      // cpu_addr moves mid-fetch; afterwards the new address misses and refills back-to-back
      tick();
      data_tag    = 32'h55550000;
      wait_cycles = 0;
      for (int i = 0; i < 4; i++) addr_q.push_back(15'h0450 + 15'(i));
      for (int i = 0; i < 4; i++) addr_q.push_back(15'h7FFC + 15'(i));
      line_q.push_back(128'h55550000_55550001_55550002_55550003);
      line_q.push_back(128'h55550000_55550001_55550002_55550003);
      stall_q.push_back(14);
      cpu_addr = 15'h0450;
      cpu_rd   = 1'b1;
      wait_words(2, 20);
      tick();
      cpu_addr = 15'h7FFF;
      wait_fills(2, 60);
      tick();
      tick();
      @(negedge clk);

`ifdef CACHE_REFILL_STATS_EN
      rst = 1'b1;
      @(negedge clk);
      check("miss_count_reset", miss_count, 32'd0);
      rst = 1'b0;
      refill(15'h0100, 15'h0100, 32'h01000000,
             128'h01000000_01000001_01000002_01000003, 0, 7);
      refill(15'h0200, 15'h0200, 32'h02000000,
             128'h02000000_02000001_02000002_02000003, 0, 7);
      refill(15'h0300, 15'h0300, 32'h03000000,
             128'h03000000_03000001_03000002_03000003, 0, 7);
      check("miss_count_3", miss_count, 32'd3);
      force dut.miss_count_reg = 32'hFFFFFFFF;
      @(negedge clk);
      release dut.miss_count_reg;
      refill(15'h0400, 15'h0400, 32'h04000000,
             128'h04000000_04000001_04000002_04000003, 0, 7);
      check("miss_count_wrap", miss_count, 32'd0);
`endif

      repeat (4) @(negedge clk);
      check("addr_q_drained", addr_q.size(), 0);
      check("line_q_drained", line_q.size(), 0);
      check("stall_q_drained", stall_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
